// File: rtl/row_pointer_encoder.sv
// row_pointer_encoder
//
// Purpose:
//   Counts the nonzero weights in each kernel row of ROW_LEN weights and packs
//   each row's count into a CNT_W-bit field of a PW-bit pointer word. The first
//   row of a word sits in the MSBs. A word is emitted when it holds
//   PTRS_PER_WORD rows, or when the job's last row completes. A partial final
//   word has its unwritten fields at zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      job-start pulse; honoured only when idle
//   num_rows   rows in the job (16 bits), sampled on start
//   busy       high while a job is active (ACCUM or EMIT)
//   w_valid    weight stream valid
//   w_ready    weight stream ready; high only in ACCUM
//   w_data     weight value (DATA_W bits)
//   ptr_valid  pointer word valid; high in EMIT
//   ptr_ready  pointer word ready
//   ptr_word   packed row-pointer word (PW = CNT_W*PTRS_PER_WORD bits)
//   ptr_last   marks the word that holds the job's final row
//   done       one-cycle job-complete pulse
//   nz_total   (only with RPTR_STATS_EN) saturating count of accepted
//              nonzero weights in the current/last job
//
// Configuration macro:
//   RPTR_STATS_EN  adds the nz_total output and its counter.
//
// Constraint: ROW_LEN must not exceed 2**CNT_W - 1, so that both the
// weight-in-row counter and the nonzero count fit in CNT_W bits.

module row_pointer_encoder #(
  parameter int DATA_W        = 8,
  parameter int ROW_LEN       = 3,
  parameter int CNT_W         = 3,
  parameter int PTRS_PER_WORD = 36,
  localparam int PW           = CNT_W * PTRS_PER_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_rows,
  output logic              busy,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              ptr_valid,
  input  logic              ptr_ready,
  output logic [PW-1:0]     ptr_word,
  output logic              ptr_last,
`ifdef RPTR_STATS_EN
  output logic [15:0]       nz_total,
`endif
  output logic              done
);

  // Width of the field index within a word; at least one bit so that a
  // single-field configuration still elaborates.
  localparam int K_W = (PTRS_PER_WORD > 1) ? $clog2(PTRS_PER_WORD) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [15:0]        r_rows_total;
  logic [15:0]        r_rows_done;
  logic [CNT_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]   r_nz;
  logic [K_W-1:0]     r_k;
  logic [PW-1:0]      r_word;
  logic               r_busy;
  logic               r_w_ready;
  logic               r_ptr_valid;
  logic               r_ptr_last;
  logic               r_done;

  logic               w_accept;
  logic               w_nonzero;
  logic [CNT_W-1:0]   w_nz_next;
  logic               w_row_end;
  logic [15:0]        w_rows_done_next;
  logic               w_job_end;
  logic               w_word_full;

  // w_ready is registered and is high exactly in ACCUM, so it doubles as the
  // state qualifier for accepting a weight.
  assign w_accept         = r_w_ready && w_valid;
  assign w_nonzero        = |w_data;
  assign w_nz_next        = r_nz + CNT_W'(w_nonzero);
  assign w_row_end        = (r_wcnt == CNT_W'(ROW_LEN - 1));
  assign w_rows_done_next = r_rows_done + 16'd1;
  assign w_job_end        = (w_rows_done_next == r_rows_total);
  assign w_word_full      = (r_k == K_W'(PTRS_PER_WORD - 1));

  // Control FSM and datapath. Outputs are registered and updated together
  // with the state so that each one reflects the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rows_total <= '0;
      r_rows_done  <= '0;
      r_wcnt       <= '0;
      r_nz         <= '0;
      r_k          <= '0;
      r_word       <= '0;
      r_busy       <= 1'b0;
      r_w_ready    <= 1'b0;
      r_ptr_valid  <= 1'b0;
      r_ptr_last   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_rows != 16'd0) begin
              r_rows_total <= num_rows;
              r_rows_done  <= '0;
              r_wcnt       <= '0;
              r_nz         <= '0;
              r_k          <= '0;
              r_word       <= '0;
              r_busy       <= 1'b1;
              r_w_ready    <= 1'b1;
              r_state      <= S_ACCUM;
            end else begin
              // Empty job: report completion without ever going busy.
              r_done <= 1'b1;
            end
          end
        end

        S_ACCUM: begin
          if (w_accept) begin
            if (w_row_end) begin
              // Last weight of the row: its count lands directly in field k.
              for (int i = 0; i < PTRS_PER_WORD; i++) begin
                if (r_k == K_W'(i)) begin
                  r_word[PW-1-CNT_W*i -: CNT_W] <= w_nz_next;
                end
              end
              r_wcnt      <= '0;
              r_nz        <= '0;
              r_rows_done <= w_rows_done_next;
              if (w_word_full || w_job_end) begin
                r_state     <= S_EMIT;
                r_w_ready   <= 1'b0;
                r_ptr_valid <= 1'b1;
                r_ptr_last  <= w_job_end;
              end else begin
                r_k <= r_k + K_W'(1);
              end
            end else begin
              r_wcnt <= r_wcnt + CNT_W'(1);
              r_nz   <= w_nz_next;
            end
          end
        end

        S_EMIT: begin
          // Word, last flag and valid are held untouched until the handshake.
          if (ptr_ready) begin
            r_ptr_valid <= 1'b0;
            r_ptr_last  <= 1'b0;
            if (r_ptr_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_word    <= '0;
              r_k       <= '0;
              r_w_ready <= 1'b1;
              r_state   <= S_ACCUM;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_w_ready   <= 1'b0;
          r_ptr_valid <= 1'b0;
          r_ptr_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign w_ready   = r_w_ready;
  assign ptr_valid = r_ptr_valid;
  assign ptr_word  = r_word;
  assign ptr_last  = r_ptr_last;
  assign done      = r_done;

`ifdef RPTR_STATS_EN
  logic [15:0] r_nz_total;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Cleared by any start seen in IDLE; otherwise it holds across done so the
  // last job's total stays readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nz_total <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_nz_total <= '0;
    end else if (w_accept && w_nonzero) begin
      r_nz_total <= sat_inc16(r_nz_total);
    end
  end

  assign nz_total = r_nz_total;
`endif

endmodule

// File: tb/tb_row_pointer_encoder.sv
module tb_row_pointer_encoder;

  localparam int PW = 108;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   num_rows = 16'd0;
  logic          busy;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [7:0]    w_data = 8'd0;
  logic          ptr_valid;
  logic          ptr_ready = 1'b0;
  logic [PW-1:0] ptr_word;
  logic          ptr_last;
  logic          done;
`ifdef RPTR_STATS_EN
  logic [15:0]   nz_total;
`endif

  row_pointer_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .busy      (busy),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .ptr_valid (ptr_valid),
    .ptr_ready (ptr_ready),
    .ptr_word  (ptr_word),
    .ptr_last  (ptr_last),
`ifdef RPTR_STATS_EN
    .nz_total  (nz_total),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkw(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- ptr_ready driver ----------------
  // rmode 0: always ready; 1: random; 2: stall each word for 10 cycles.
  int rmode = 0;
  int hold  = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: ptr_ready = 1'b1;
      1: ptr_ready = 1'($urandom_range(0, 1));
      default: begin
        if (ptr_valid && hold < 10) begin
          ptr_ready = 1'b0;
          hold++;
        end else if (ptr_valid) begin
          ptr_ready = 1'b1;
        end else begin
          ptr_ready = 1'b0;
          hold = 0;
        end
      end
    endcase
  end

  // ---------------- output monitor ----------------
  logic [PW-1:0] got_w[$];
  logic          got_l[$];
  int            hs_cyc = 0;
  logic          held_v = 1'b0;
  logic [PW-1:0] held_w = '0;
  logic          held_l = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (held_v) begin
        check1("hold_valid", ptr_valid, 1'b1);
        checkw("hold_word", ptr_word, held_w);
        check1("hold_last", ptr_last, held_l);
      end
      if (ptr_valid) check1("w_ready_in_emit", w_ready, 1'b0);
      if (ptr_valid && ptr_ready) begin
        got_w.push_back(ptr_word);
        got_l.push_back(ptr_last);
        hs_cyc = cyc;
      end
      held_v = ptr_valid && !ptr_ready;
      held_w = ptr_word;
      held_l = ptr_last;
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] wq[$];
  int vmode = 0;   // 0: w_valid always high, 1: random gaps

  task automatic feed(input int n);
    int idx = 0;
    int budget = 0;
    logic acc;
    while (idx < n && budget < 20000) begin
      w_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      w_data  = wq[idx];
      @(negedge clk);
      acc = w_valid && w_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget++;
    end
    w_valid = 1'b0;
    w_data  = 8'd0;
    if (idx < n) begin
      vecs++;
      errs++;
      $display("FAIL feed_timeout: got %0d weights accepted expected %0d", idx, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_w_ready"}, w_ready, 1'b0);
    check1({tag, "_ptr_valid"}, ptr_valid, 1'b0);
    check1({tag, "_ptr_last"}, ptr_last, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    checkw({tag, "_ptr_word"}, ptr_word, '0);
`ifdef RPTR_STATS_EN
    checkn({tag, "_nz_total"}, int'(nz_total), 0);
`endif
  endtask

  task automatic run_job(input int n);
    int b = 0;
    got_w.delete();
    got_l.delete();
    @(posedge clk); #1;
    start = 1'b1;
    num_rows = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check1("busy_after_start", busy, 1'b1);
    feed(3 * n);
    @(negedge clk);
    check1("valid_latency", ptr_valid, 1'b1);
    while (!done && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (!done) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end else begin
      checkn("done_after_handshake", cyc, hs_cyc + 1);
      check1("busy_at_done", busy, 1'b0);
    end
    @(negedge clk);
    check1("done_one_cycle", done, 1'b0);
`ifdef RPTR_STATS_EN
    begin
      int nz = 0;
      for (int i = 0; i < 3 * n; i++) if (wq[i] != 8'd0) nz++;
      checkn("nz_total", int'(nz_total), nz);
    end
`endif
  endtask

  // Reference: one 3-bit field per row, row r in word r/36 at field r%36,
  // field f occupying bits [107-3f -: 3]; final word carries the last flag.
  logic [PW-1:0] exp_w[$];
  logic          exp_l[$];

  task automatic build_exp(input int n);
    int nw;
    exp_w.delete();
    exp_l.delete();
    nw = (n + 35) / 36;
    for (int w = 0; w < nw; w++) begin
      logic [PW-1:0] word = '0;
      for (int f = 0; f < 36; f++) begin
        int r = w * 36 + f;
        if (r < n) begin
          int cnt = 0;
          for (int j = 0; j < 3; j++) if (wq[3 * r + j] != 8'd0) cnt++;
          word = word | (PW'(cnt) << (105 - 3 * f));
        end
      end
      exp_w.push_back(word);
      exp_l.push_back(w == nw - 1);
    end
  endtask

  task automatic compare_exp(input string tag);
    checkn({tag, "_word_count"}, got_w.size(), exp_w.size());
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checkw({tag, "_word"}, got_w[i], exp_w[i]);
      check1({tag, "_last"}, got_l[i], exp_l[i]);
    end
  endtask

  typedef struct {
    int            nrows;
    logic [23:0]   pat;     // {w0, w1, w2} repeated for every row
    int            rmode;
    int            nw;
    logic [PW-1:0] w0;
    logic [PW-1:0] w1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{36, 24'h050505, 0, 1, {36{3'b011}}, '0};
    tbl[1] = '{72, 24'h050000, 0, 2, {36{3'b001}}, {36{3'b001}}};
    tbl[2] = '{1,  24'h000700, 0, 1, {3'b001, 105'd0}, '0};
    tbl[3] = '{72, 24'h050000, 2, 2, {36{3'b001}}, {36{3'b001}}};
    tbl[4] = '{37, 24'h050505, 1, 2, {36{3'b011}}, {3'b011, 105'd0}};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Table-driven jobs
    for (int t = 0; t < 5; t++) begin
      logic [PW-1:0] ew;
      logic [23:0]   p;
      p = tbl[t].pat;
      wq.delete();
      for (int r = 0; r < tbl[t].nrows; r++)
        for (int j = 0; j < 3; j++) wq.push_back(p[23 - 8 * j -: 8]);
      rmode = tbl[t].rmode;
      vmode = 0;
      run_job(tbl[t].nrows);
      checkn("tbl_word_count", got_w.size(), tbl[t].nw);
      for (int i = 0; i < got_w.size() && i < tbl[t].nw; i++) begin
        ew = (i == 0) ? tbl[t].w0 : tbl[t].w1;
        checkw("tbl_word", got_w[i], ew);
        check1("tbl_last", got_l[i], logic'(i == tbl[t].nw - 1));
      end
    end

    // Empty job: done pulse, never busy
    rmode = 0;
    @(posedge clk); #1;
    start = 1'b1;
    num_rows = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check1("zero_done", done, 1'b1);
    check1("zero_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check1("zero_done_low", done, 1'b0);
      check1("zero_busy_low", busy, 1'b0);
    end

    // Randomized jobs against the reference model
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 80);
      wq.delete();
      for (int i = 0; i < 3 * n; i++)
        wq.push_back($urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00);
      rmode = 1;
      vmode = 1;
      run_job(n);
      build_exp(n);
      compare_exp("rand");
    end

    // Reset in the middle of a job, then a fresh two-row job
    rmode = 0;
    vmode = 0;
    wq.delete();
    for (int i = 0; i < 60; i++) wq.push_back(8'($urandom_range(0, 255)));
    @(posedge clk); #1;
    start = 1'b1;
    num_rows = 16'd20;
    @(posedge clk); #1;
    start = 1'b0;
    feed(50);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midjob_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wq.delete();
    wq.push_back(8'h05); wq.push_back(8'h05); wq.push_back(8'h00);
    wq.push_back(8'h00); wq.push_back(8'h00); wq.push_back(8'h03);
    run_job(2);
    checkn("post_reset_count", got_w.size(), 1);
    if (got_w.size() > 0) begin
      checkw("post_reset_word", got_w[0], {3'b010, 3'b001, 102'd0});
      check1("post_reset_last", got_l[0], 1'b1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/row_pointer_encoder.md
ROW_POINTER_ENCODER -- requirements
Module: row_pointer_encoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the weight width in bits.
REQ-002 The block SHALL have parameter ROW_LEN, default 3, meaning the number of weights per kernel row.
REQ-003 The block SHALL have parameter CNT_W, default 3, meaning the width of one row-pointer field; ROW_LEN SHALL be at most 2^CNT_W-1.
REQ-004 The block SHALL have parameter PTRS_PER_WORD, default 36, meaning the number of fields per output word; PW = CNT_W*PTRS_PER_WORD (108 at defaults).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, a job-start pulse.
REQ-008 The block SHALL have port num_rows, input, 16 bits, the rows in the job, sampled on start.
REQ-009 The block SHALL have port busy, output, 1 bit, asserted while a job is active.
REQ-010 The block SHALL have ports w_valid (input, 1 bit), w_ready (output, 1 bit) and w_data (input, DATA_W bits), forming the weight stream.
REQ-011 The block SHALL have ports ptr_valid (output, 1 bit), ptr_ready (input, 1 bit), ptr_word (output, PW bits) and ptr_last (output, 1 bit), forming the packed pointer stream.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle job-complete pulse.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, ACCUM and EMIT; busy SHALL be 1 in ACCUM and EMIT.
REQ-014 In IDLE, start with num_rows>0 SHALL latch num_rows, clear the counters and the word, and enter ACCUM next cycle.
REQ-015 In IDLE, start with num_rows==0 SHALL pulse done the next cycle and remain in IDLE.
REQ-016 start SHALL be ignored while busy.
REQ-017 w_ready SHALL equal 1 only in ACCUM; a weight is accepted when w_valid && w_ready.
REQ-018 Each accepted weight with w_data != 0 SHALL increment the row's nonzero count.
REQ-019 On the ROW_LEN-th accepted weight of a row, the final count SHALL be written into field k (k = row index within word).
REQ-020 Field k SHALL occupy ptr_word[PW-1-CNT_W*k -: CNT_W], so the first row sits in the MSBs.
REQ-021 After a row completes, if k==PTRS_PER_WORD-1 or it is the last job row, the block SHALL enter EMIT next cycle; otherwise it SHALL stay in ACCUM with k+1.
REQ-022 Unwritten fields of a final partial word SHALL be 0.
REQ-023 In EMIT, ptr_valid SHALL be 1, and ptr_word and ptr_last SHALL stay stable until ptr_ready.
REQ-024 ptr_last SHALL be 1 only on the word containing the job's final row.
REQ-025 Latency: ptr_valid SHALL rise the cycle after the word's last weight is accepted.
REQ-026 On an EMIT handshake with ptr_last=0, the block SHALL clear the word, set k=0 and return to ACCUM.
REQ-027 On an EMIT handshake with ptr_last=1, the block SHALL return to IDLE and pulse done in that same next cycle.
REQ-028 A word SHALL be emitted at most once, with no gaps or duplicates under any ptr_ready pattern.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, with busy, w_ready, ptr_valid, ptr_last and done at 0, ptr_word at 0, and all counters at 0.
REQ-030 Reset mid-job SHALL abandon the job; after release the block SHALL accept a new start.

Configuration
REQ-031 With macro RPTR_STATS_EN defined, the block SHALL add output nz_total[15:0], counting accepted nonzero weights.
REQ-032 nz_total SHALL clear on an accepted start, saturate at 16'hFFFF, reset to 0, and hold its value after done.
REQ-033 Without RPTR_STATS_EN, the port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Bench SHALL cover: num_rows=36, all 108 weights 8'h05, ptr_ready=1 -> one word of 36 fields 3'b011, ptr_last=1, done one cycle after handshake.
REQ-035 Bench SHALL cover: num_rows=72, weight pattern {5,0,0} per row -> two words of all fields 3'b001, ptr_last only on the second.
REQ-036 Bench SHALL cover: num_rows=1, weights {0,7,0} -> ptr_word[107:105]=3'b001, rest 0, ptr_last=1.
REQ-037 Bench SHALL cover: ptr_ready low for 10 cycles during EMIT -> ptr_valid/word held stable, w_ready=0, no weight loss.
REQ-038 Bench SHALL cover: rst_n pulsed after 50 weights -> all outputs 0 and IDLE; a new start with num_rows=2 yields one correct word.
REQ-039 Bench SHALL cover: start with num_rows=0 -> done pulse, busy never asserted; with RPTR_STATS_EN, nz_total matches the count of nonzero weights.
